// File: rtl/junction_pkg.sv
// Shared types and helpers for the four-approach junction scheduler.
// Phase encodings match the external phase port.
package junction_pkg;

  localparam int N_ROADS = 4;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10
  } phase_e;

  // First set bit of cand searching upward from last+1, wrapping.
  function automatic logic [1:0] rr_pick(
    input logic [N_ROADS-1:0] cand,
    input logic [1:0]         last
  );
    logic [1:0] idx;
    rr_pick = last;
    for (int i = N_ROADS; i >= 1; i--) begin
      idx = last + 2'(i);
      if (cand[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Timing-tick prescaler: one-cycle tick every TICK_DIV clocks.
// With TICK_DIV=1 the tick is permanently high.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = (r_cnt == C_LAST);
  assign tick   = w_tick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/junction_scheduler.sv
// Four-approach junction light scheduler: round-robin grant with
// congestion priority/extension and emergency pre-emption.
module junction_scheduler
  import junction_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int GREEN_MIN   = 3,
  parameter int GREEN_MAX   = 6,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] request,
  input  logic [3:0] congestion,
  input  logic       emergency_valid,
  input  logic [1:0] emergency_road,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic [1:0] grant_road,
  output logic [1:0] phase,
  output logic       emergency_ack
);

  // Saturation point covers every phase threshold so none can stall.
  localparam int T_A   = (GREEN_MAX > YELLOW_TIME) ? GREEN_MAX : YELLOW_TIME;
  localparam int T_SAT = (T_A > ALLRED_TIME) ? T_A : ALLRED_TIME;
  localparam int T_LOG = $clog2(T_SAT + 1);
  localparam int TW    = (T_LOG < 2) ? 2 : T_LOG;
  localparam int TW1   = TW + 1;

  localparam logic [TW-1:0] C_SAT  = TW'(T_SAT);
  localparam logic [TW:0]   C_GMIN = TW1'(GREEN_MIN);
  localparam logic [TW:0]   C_GMAX = TW1'(GREEN_MAX);
  localparam logic [TW:0]   C_YEL  = TW1'(YELLOW_TIME);
  localparam logic [TW:0]   C_AR   = TW1'(ALLRED_TIME);

  logic          w_tick;
  phase_e        r_phase;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_green;
  logic [3:0]    r_yellow;
  logic [1:0]    r_grant;
  logic [1:0]    r_last;
  logic          r_ack;

  logic [TW:0]   w_tn;
  logic [TW-1:0] w_timer_inc;
  logic [3:0]    w_cong_req;
  logic [3:0]    w_cand;
  logic [3:0]    w_others;
  logic [1:0]    w_win;
  logic          w_want;
  logic          w_cong_g;
  logic          w_foreign_emg;
  logic          w_g_exit;
  logic          w_ar_done;
  logic          w_y_done;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  assign w_tn        = {1'b0, r_timer} + TW1'(1);
  assign w_timer_inc = (r_timer == C_SAT) ? r_timer : r_timer + TW'(1);

  assign w_cong_req = request & congestion;
  assign w_cand     = (w_cong_req != 4'b0) ? w_cong_req : request;
  assign w_win      = emergency_valid ? emergency_road
                                      : rr_pick(w_cand, r_last);
  assign w_want     = emergency_valid | (|request);

  // r_green is one-hot on the served road while in GREEN.
  assign w_others      = request & ~r_green;
  assign w_cong_g      = |(congestion & r_green);
  assign w_foreign_emg = emergency_valid && (emergency_road != r_grant);

  assign w_g_exit = w_foreign_emg
                  | (!emergency_valid & w_tick & (|w_others)
                     & ((!w_cong_g & (w_tn >= C_GMIN))
                        | (w_tn >= C_GMAX)));

  assign w_ar_done = w_tick & (w_tn >= C_AR);
  assign w_y_done  = w_tick & (w_tn >= C_YEL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase  <= PH_ALLRED;
      r_timer  <= '0;
      r_green  <= 4'b0;
      r_yellow <= 4'b0;
      r_grant  <= 2'd0;
      r_last   <= 2'd3;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_phase)
        PH_ALLRED: begin
          if (w_ar_done && w_want) begin
            r_phase <= PH_GREEN;
            r_timer <= '0;
            r_green <= 4'b0001 << w_win;
            r_grant <= w_win;
            r_last  <= w_win;
            r_ack   <= emergency_valid;
          end else if (w_tick) begin
            r_timer <= w_timer_inc;
          end
        end
        PH_GREEN: begin
          if (w_g_exit) begin
            r_phase  <= PH_YELLOW;
            r_timer  <= '0;
            r_green  <= 4'b0;
            r_yellow <= r_green;
          end else if (w_tick) begin
            r_timer <= w_timer_inc;
          end
        end
        PH_YELLOW: begin
          if (w_y_done) begin
            r_phase  <= PH_ALLRED;
            r_timer  <= '0;
            r_yellow <= 4'b0;
          end else if (w_tick) begin
            r_timer <= w_timer_inc;
          end
        end
        default: begin
          r_phase  <= PH_ALLRED;
          r_timer  <= '0;
          r_green  <= 4'b0;
          r_yellow <= 4'b0;
        end
      endcase
    end
  end

  assign green         = r_green;
  assign yellow        = r_yellow;
  assign red           = ~(r_green | r_yellow);
  assign grant_road    = r_grant;
  assign phase         = r_phase;
  assign emergency_ack = r_ack;

endmodule
